// File: rtl/seg_pkg.sv
// Shared definitions for the serial seven-segment display driver:
// controller state encoding and the legal range of the s_clk divider.
package seg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      DONE  = 3'd4
   } seg_state_t;

   localparam int SCLK_DIV_MIN = 1;
   localparam int SCLK_DIV_MAX = 15;

endpackage

// File: rtl/seg_bit_timer.sv
// Half-period timer for the shift clock: issues a one-cycle tick every
// SCLK_DIV cycles while running, restarting from zero whenever cleared.
module seg_bit_timer
   import seg_pkg::*;
#(
   parameter int SCLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   // Out-of-range divider values are pinned to the nearest legal bound.
   localparam int DIV = (SCLK_DIV < SCLK_DIV_MIN) ? SCLK_DIV_MIN :
                        (SCLK_DIV > SCLK_DIV_MAX) ? SCLK_DIV_MAX : SCLK_DIV;
   localparam logic [3:0] LAST = 4'(DIV - 1);

   logic [3:0] div_cnt;

   assign tick = !clear && (div_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (clear || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/seg_serial_driver.sv
// Streams eight display bytes (7 down to 0, MSB first) into an external
// shift-register chain, then strobes the storage latch once.
module seg_serial_driver
   import seg_pkg::*;
#(
   parameter int SCLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [2:0] sel,
   input  logic [7:0] din,
   output logic       busy,
   output logic       done,
   output logic       s_clk,
   output logic       s_dat,
   output logic       s_latch
);

   seg_state_t state, state_n;
   logic [2:0] index, index_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic       phase, phase_n;
   logic [7:0] shreg, shreg_n;
   logic       tick;
   logic       timer_clear;

   // The timer only runs while shifting or latching, so every FETCH restarts it.
   assign timer_clear = (state != SHIFT) && (state != LATCH);

   seg_bit_timer #(
      .SCLK_DIV(SCLK_DIV)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(timer_clear),
      .tick (tick)
   );

   assign sel  = index;
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // phase=0 is the s_clk-low half of a bit, phase=1 the high half.
   always_comb begin
      state_n   = state;
      index_n   = index;
      bit_cnt_n = bit_cnt;
      phase_n   = phase;
      shreg_n   = shreg;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = FETCH;
               index_n = 3'd7;
            end
         end
         FETCH: begin
            shreg_n   = din;
            bit_cnt_n = 3'd0;
            phase_n   = 1'b0;
            state_n   = SHIFT;
         end
         SHIFT: begin
            if (tick) begin
               if (!phase) begin
                  phase_n = 1'b1;
               end else begin
                  phase_n = 1'b0;
                  if (bit_cnt == 3'd7) begin
                     if (index == 3'd0) begin
                        state_n = LATCH;
                     end else begin
                        index_n = index - 3'd1;
                        state_n = FETCH;
                     end
                  end else begin
                     bit_cnt_n = bit_cnt + 3'd1;
                     shreg_n   = {shreg[6:0], 1'b0};
                  end
               end
            end
         end
         LATCH: begin
            if (tick) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         index   <= '0;
         bit_cnt <= '0;
         phase   <= 1'b0;
         shreg   <= '0;
      end else begin
         state   <= state_n;
         index   <= index_n;
         bit_cnt <= bit_cnt_n;
         phase   <= phase_n;
         shreg   <= shreg_n;
      end
   end

   // Pin values are precomputed from next-state so each pin is a bare flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_clk   <= 1'b0;
         s_dat   <= 1'b0;
         s_latch <= 1'b0;
      end else begin
         s_clk   <= (state_n == SHIFT) && phase_n;
         s_dat   <= (state_n == SHIFT) && shreg_n[7];
         s_latch <= (state_n == LATCH);
      end
   end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: a cycle-indexed model of one refresh checked
// every cycle, plus directed refreshes with hand-computed expectations.
module tb_seg_serial_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, start_b;
   logic [2:0] sel_a, sel_b;
   logic [7:0] din_a, din_b;
   logic       busy_a, done_a, s_clk_a, s_dat_a, s_latch_a;
   logic       busy_b, done_b, s_clk_b, s_dat_b, s_latch_b;
   logic [7:0] mux_a [8];
   logic [7:0] mux_b [8];

   assign din_a = mux_a[sel_a];
   assign din_b = mux_b[sel_b];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   seg_serial_driver #(.SCLK_DIV(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .sel(sel_a), .din(din_a),
      .busy(busy_a), .done(done_a), .s_clk(s_clk_a), .s_dat(s_dat_a), .s_latch(s_latch_a)
   );

   seg_serial_driver #(.SCLK_DIV(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .sel(sel_b), .din(din_b),
      .busy(busy_b), .done(done_b), .s_clk(s_clk_b), .s_dat(s_dat_b), .s_latch(s_latch_b)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected outputs for cycle t of a refresh (t=0 idle, t=1 first FETCH):
   // {busy, done, s_clk, s_dat, s_latch, fetch, sel[2:0]}
   function automatic logic [8:0] modelOut(input int t, input int d, input logic [7:0] cap);
      logic [8:0] e;
      int p, k, r, u;
      e = '0;
      p = 1 + 16 * d;
      if (t == 0) return e;
      e[8] = 1'b1;
      if (t <= 8 * p) begin
         k = (t - 1) / p;
         r = (t - 1) % p;
         if (r == 0) begin
            e[3]   = 1'b1;
            e[2:0] = 3'(7 - k);
         end else begin
            u    = r - 1;
            e[6] = ((u % (2 * d)) >= d);
            e[5] = cap[7 - u / (2 * d)];
         end
      end else if (t <= 8 * p + d) begin
         e[4] = 1'b1;
      end else begin
         e[7] = 1'b1;
      end
      return e;
   endfunction

   function automatic int nextT(input int t, input int d, input logic st);
      if (t == 0) return st ? 1 : 0;
      if (t == 8 * (1 + 16 * d) + d + 1) return 0;
      return t + 1;
   endfunction

   int t_a = 0, t_b = 0;
   logic [7:0] cap_a, cap_b;
   logic [8:0] e_a, e_b, m_a, m_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_a <= 0;
         t_b <= 0;
      end else begin
         m_a = modelOut(t_a, 2, cap_a);
         m_b = modelOut(t_b, 1, cap_b);
         if (m_a[3]) cap_a <= mux_a[m_a[2:0]];
         if (m_b[3]) cap_b <= mux_b[m_b[2:0]];
         t_a <= nextT(t_a, 2, start_a);
         t_b <= nextT(t_b, 1, start_b);
      end
   end

   always @(negedge clk) begin
      e_a = modelOut(t_a, 2, cap_a);
      e_b = modelOut(t_b, 1, cap_b);
      checkOutput("busy_a", busy_a, e_a[8]);
      checkOutput("done_a", done_a, e_a[7]);
      checkOutput("s_clk_a", s_clk_a, e_a[6]);
      checkOutput("s_dat_a", s_dat_a, e_a[5]);
      checkOutput("s_latch_a", s_latch_a, e_a[4]);
      if (e_a[3]) checkOutput("sel_a", sel_a, e_a[2:0]);
      checkOutput("busy_b", busy_b, e_b[8]);
      checkOutput("done_b", done_b, e_b[7]);
      checkOutput("s_clk_b", s_clk_b, e_b[6]);
      checkOutput("s_dat_b", s_dat_b, e_b[5]);
      checkOutput("s_latch_b", s_latch_b, e_b[4]);
      if (e_b[3]) checkOutput("sel_b", sel_b, e_b[2:0]);
   end

   // Pin-level observers: bits taken on s_clk rising, pulse counts and widths.
   logic [63:0] bits_a, bits_b;
   int nbits_a = 0, latch_cnt_a = 0, latch_len_a = 0, cur_len_a = 0;
   int sclk_period_b = 0, last_rise_b = 0;
   logic prev_sclk_a = 1'b0, prev_sclk_b = 1'b0, prev_latch_a = 1'b0;
   int done_q[$];

   always @(negedge clk) begin
      if (s_clk_a && !prev_sclk_a) begin
         bits_a  = {bits_a[62:0], s_dat_a};
         nbits_a = nbits_a + 1;
      end
      if (s_clk_b && !prev_sclk_b) begin
         bits_b        = {bits_b[62:0], s_dat_b};
         sclk_period_b = cyc - last_rise_b;
         last_rise_b   = cyc;
      end
      if (s_latch_a && !prev_latch_a) latch_cnt_a = latch_cnt_a + 1;
      if (s_latch_a) cur_len_a = cur_len_a + 1;
      if (!s_latch_a && prev_latch_a) begin
         latch_len_a = cur_len_a;
         cur_len_a   = 0;
      end
      if (done_a) done_q.push_back(cyc);
      prev_sclk_a  = s_clk_a;
      prev_sclk_b  = s_clk_b;
      prev_latch_a = s_latch_a;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit use_b, input bit release_reset, output int lat);
      int  c0;
      bit  seen;
      if (use_b) start_b = 1'b1;
      else       start_a = 1'b1;
      if (release_reset) rst_n = 1'b1;
      tick();
      c0      = cyc;
      start_a = 1'b0;
      start_b = 1'b0;
      checkOutput(use_b ? "accept_b" : "accept_a", use_b ? busy_b : busy_a, 1);
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if ((use_b ? done_b : done_a) === 1'b1) begin
            seen = 1'b1;
            lat  = cyc - c0 + 1;
         end else begin
            tick();
         end
      end
      if (!seen) checkOutput("done_timeout", 0, 1);
   endtask

   localparam logic [63:0] BYTES_A = 64'h1716151413121110;

   initial begin
      int lat, lc, dc, nb, n0, c0;
      bit seen;
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int k = 0; k < 8; k++) begin
         mux_a[k] = 8'(8'h10 + k);
         mux_b[k] = 8'hFF;
      end
      repeat (3) tick();
      checkOutput("rst_busy", busy_a, 0);
      checkOutput("rst_done", done_a, 0);
      checkOutput("rst_sclk", s_clk_a, 0);
      checkOutput("rst_sdat", s_dat_a, 0);
      checkOutput("rst_latch", s_latch_a, 0);
      checkOutput("rst_sel", sel_a, 0);

      $display("[TB] single refresh, SCLK_DIV=2, start at reset release");
      applyStimulus(1'b0, 1'b1, lat);
      checkOutput("latency_a", lat, 267);
      checkOutput("bits_a", bits_a, BYTES_A);
      tick();
      checkOutput("latch_cnt_a", latch_cnt_a, 1);
      checkOutput("latch_len_a", latch_len_a, 2);

      $display("[TB] single refresh, SCLK_DIV=1, all ones");
      applyStimulus(1'b1, 1'b0, lat);
      checkOutput("latency_b", lat, 138);
      checkOutput("bits_b", bits_b, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("sclk_period_b", sclk_period_b, 2);
      tick();

      $display("[TB] start while busy, mux bytes changed mid-shift");
      lc = latch_cnt_a;
      dc = done_q.size();
      start_a = 1'b1;
      tick();
      c0 = cyc;
      start_a = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (done_a === 1'b1) begin
            seen = 1'b1;
         end else begin
            tick();
            start_a = 1'b0;
            if (cyc - c0 + 1 == 5) begin
               start_a  = 1'b1;
               mux_a[7] = 8'hEE;
            end
            if (cyc - c0 + 1 == 100) begin
               start_a  = 1'b1;
               mux_a[6] = 8'hDD;
            end
         end
      end
      if (!seen) checkOutput("done_timeout", 0, 1);
      start_a = 1'b0;
      repeat (5) tick();
      checkOutput("ignored_done_cnt", done_q.size() - dc, 1);
      checkOutput("ignored_latch_cnt", latch_cnt_a - lc, 1);
      checkOutput("ignored_bits", bits_a, BYTES_A);
      checkOutput("ignored_idle", busy_a, 0);
      mux_a[7] = 8'h17;
      mux_a[6] = 8'h16;

      $display("[TB] start held for three refreshes");
      n0 = done_q.size();
      start_a = 1'b1;
      for (int i = 0; i < 1200 && done_q.size() < n0 + 2; i++) tick();
      tick();
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 400 && done_q.size() < n0 + 3; i++) tick();
      if (done_q.size() < n0 + 3) begin
         checkOutput("b2b_timeout", done_q.size(), n0 + 3);
      end else begin
         checkOutput("b2b_gap1", done_q[n0 + 1] - done_q[n0], 268);
         checkOutput("b2b_gap2", done_q[n0 + 2] - done_q[n0 + 1], 268);
      end
      repeat (3) tick();
      checkOutput("b2b_stopped", busy_a, 0);

      $display("[TB] reset at bit 30, then full refresh");
      lc = latch_cnt_a;
      nb = nbits_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 200 && nbits_a < nb + 30; i++) tick();
      checkOutput("reached_bit30", nbits_a - nb, 30);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy_a, 0);
      checkOutput("abort_done", done_a, 0);
      checkOutput("abort_sclk", s_clk_a, 0);
      checkOutput("abort_sdat", s_dat_a, 0);
      checkOutput("abort_latch", s_latch_a, 0);
      checkOutput("abort_sel", sel_a, 0);
      repeat (3) tick();
      checkOutput("abort_no_latch", latch_cnt_a - lc, 0);
      applyStimulus(1'b0, 1'b1, lat);
      checkOutput("post_reset_latency", lat, 267);
      checkOutput("post_reset_bits", bits_a, BYTES_A);
      repeat (3) tick();
      checkOutput("post_reset_latch", latch_cnt_a - lc, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
